// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and defaults for the hazard/stall controller
package hazard_stall_ctrl_pkg;

    localparam int CTRL_W_DEF = 10;
    localparam int REG_AW_DEF = 5;
    localparam int BCNT_W     = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_HOLD = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
        return (v == {BCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for the hazard/stall controller
interface hazard_stall_ctrl_if #(
    parameter int CTRL_W = hazard_stall_ctrl_pkg::CTRL_W_DEF,
    parameter int REG_AW = hazard_stall_ctrl_pkg::REG_AW_DEF
);
    logic [CTRL_W-1:0] ctrl_in;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rt;
    logic              jump_in;
    logic              branch_taken;
    logic              mem_busy;
    logic [CTRL_W-1:0] ctrl_out;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic [15:0]       bubble_cnt;

    // Pipeline side drives the decode/EX observations and consumes the enables.
    modport master (
        output ctrl_in, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               jump_in, branch_taken, mem_busy,
        input  ctrl_out, pc_write, ifid_write, idex_write,
               ifid_flush, idex_flush, bubble_cnt
    );

    modport slave (
        input  ctrl_in, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               jump_in, branch_taken, mem_busy,
        output ctrl_out, pc_write, ifid_write, idex_write,
               ifid_flush, idex_flush, bubble_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// rtl/hazard_stall_ctrl_hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    output logic              lu_o
);

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign lu_o = ex_mem_read_i && (ex_rt_i != '0) &&
                  ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, branch/jump flush and freeze control with bubble counter
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int LU_CYCLES = 1,
    parameter int FL_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [2:0] LU_REM = 3'(LU_CYCLES - 1);
    localparam logic [2:0] FL_REM = 3'(FL_CYCLES - 1);

    state_e              state_q, state_d;
    logic [2:0]          rem_q, rem_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;

    logic                lu;
    logic                bubble;
    logic [CTRL_W-1:0]   ctrl_out;
    logic                pc_write, ifid_write, idex_write, ifid_flush, idex_flush;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_rt_i       (bus.ex_rt),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .lu_o          (lu)
    );

    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        ctrl_out   = '0;
        bubble     = 1'b0;
        state_d    = state_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;

        if (!reset) begin
            if (bus.mem_busy) begin
                ctrl_out = bus.ctrl_in;
            end else if (bus.branch_taken) begin
                // A taken branch squashes both younger stages and overrides any load-use hold.
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                idex_write = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                bubble     = 1'b1;
                rem_d      = FL_REM;
                state_d    = (FL_REM == 3'd0) ? RUN : FLUSH;
            end else if ((state_q == RUN && lu) || state_q == LU_HOLD) begin
                idex_write = 1'b1;
                bubble     = 1'b1;
                if (state_q == RUN) begin
                    rem_d   = LU_REM;
                    state_d = (LU_REM == 3'd0) ? RUN : LU_HOLD;
                end else if (rem_q <= 3'd1) begin
                    rem_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    rem_d   = rem_q - 3'd1;
                end
            end else if (state_q == FLUSH) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                idex_write = 1'b1;
                ifid_flush = 1'b1;
                ctrl_out   = bus.ctrl_in;
                if (rem_q <= 3'd1) begin
                    rem_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    rem_d   = rem_q - 3'd1;
                end
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                idex_write = 1'b1;
                ifid_flush = bus.jump_in;
                ctrl_out   = bus.ctrl_in;
            end
            if (bubble) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ctrl_out   = ctrl_out;
    assign bus.pc_write   = pc_write;
    assign bus.ifid_write = ifid_write;
    assign bus.idex_write = idex_write;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam logic [9:0] CTRL = 10'h2A5;

    logic clk;
    logic reset_a, reset_b;

    logic [9:0] ctrl_in;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, jump_in, branch_taken, mem_busy;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl_if #(.CTRL_W(10), .REG_AW(5)) ia ();
    hazard_stall_ctrl_if #(.CTRL_W(10), .REG_AW(5)) ib ();

    assign ia.ctrl_in = ctrl_in;       assign ib.ctrl_in = ctrl_in;
    assign ia.id_rs = id_rs;           assign ib.id_rs = id_rs;
    assign ia.id_rt = id_rt;           assign ib.id_rt = id_rt;
    assign ia.id_uses_rt = id_uses_rt; assign ib.id_uses_rt = id_uses_rt;
    assign ia.ex_mem_read = ex_mem_read; assign ib.ex_mem_read = ex_mem_read;
    assign ia.ex_rt = ex_rt;           assign ib.ex_rt = ex_rt;
    assign ia.jump_in = jump_in;       assign ib.jump_in = jump_in;
    assign ia.branch_taken = branch_taken; assign ib.branch_taken = branch_taken;
    assign ia.mem_busy = mem_busy;     assign ib.mem_busy = mem_busy;

    hazard_stall_ctrl #(.CTRL_W(10), .REG_AW(5), .LU_CYCLES(1), .FL_CYCLES(1)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ia)
    );

    hazard_stall_ctrl #(.CTRL_W(10), .REG_AW(5), .LU_CYCLES(3), .FL_CYCLES(2)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ib)
    );

    logic [4:0] en_a, en_b;
    assign en_a = {ia.pc_write, ia.ifid_write, ia.idex_write, ia.ifid_flush, ia.idex_flush};
    assign en_b = {ib.pc_write, ib.ifid_write, ib.idex_write, ib.ifid_flush, ib.idex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic j,
                         input logic br, input logic busy);
        ex_mem_read  = mr;
        ex_rt        = ert;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        jump_in      = j;
        branch_taken = br;
        mem_busy     = busy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lu5();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        ctrl_in = CTRL;
        reset_a = 1'b1;
        reset_b = 1'b1;
        idle();

        @(negedge clk); #1;
        chk("rst_a_ctrl", 16'(ia.ctrl_out), 16'h0);
        chk("rst_a_en", 16'(en_a), 16'h0);
        chk("rst_a_cnt", ia.bubble_cnt, 16'h0);
        chk("rst_b_en", 16'(en_b), 16'h0);

        @(negedge clk); reset_a = 1'b0; reset_b = 1'b0; #1;
        chk("norm_a_en", 16'(en_a), 16'b11100);
        chk("norm_a_ctrl", 16'(ia.ctrl_out), 16'(CTRL));

        // Single load-use bubble on A, three on B
        @(negedge clk); lu5(); #1;
        chk("lu1_a_en", 16'(en_a), 16'b00100);
        chk("lu1_a_ctrl", 16'(ia.ctrl_out), 16'h0);
        chk("lu1_b_en", 16'(en_b), 16'b00100);
        @(negedge clk); idle(); #1;
        chk("lu1_a_after_en", 16'(en_a), 16'b11100);
        chk("lu1_a_cnt", ia.bubble_cnt, 16'd1);
        chk("lu3_b_hold1_en", 16'(en_b), 16'b00100);
        chk("lu3_b_hold1_ctrl", 16'(ib.ctrl_out), 16'h0);
        chk("lu3_b_cnt1", ib.bubble_cnt, 16'd1);
        @(negedge clk); #1;
        chk("lu3_b_hold2_en", 16'(en_b), 16'b00100);
        chk("lu3_b_cnt2", ib.bubble_cnt, 16'd2);
        @(negedge clk); #1;
        chk("lu3_b_run_en", 16'(en_b), 16'b11100);
        chk("lu3_b_cnt3", ib.bubble_cnt, 16'd3);

        // Load to r0 never stalls
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("r0_a_en", 16'(en_a), 16'b11100);
        chk("r0_a_ctrl", 16'(ia.ctrl_out), 16'(CTRL));
        chk("r0_b_en", 16'(en_b), 16'b11100);

        // rt match counts only when the ID instruction reads rt
        @(negedge clk); drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("rt_use_a_en", 16'(en_a), 16'b00100);
        @(negedge clk); drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("rt_nouse_a_en", 16'(en_a), 16'b11100);
        chk("rt_a_cnt", ia.bubble_cnt, 16'd2);

        // Reset mid-LU_HOLD on B
        @(negedge clk); idle(); reset_b = 1'b1; #1;
        chk("rst_hold_b_en", 16'(en_b), 16'h0);
        chk("rst_hold_b_ctrl", 16'(ib.ctrl_out), 16'h0);
        chk("rst_hold_b_cnt", ib.bubble_cnt, 16'h0);
        @(negedge clk); reset_b = 1'b0; #1;
        chk("rst_hold_b_run", 16'(en_b), 16'b11100);

        // Branch during LU_HOLD on B (FL_CYCLES=2), A with FL_CYCLES=1
        @(negedge clk); lu5(); #1;
        chk("br_b_c1_en", 16'(en_b), 16'b00100);
        @(negedge clk); idle(); #1;
        chk("br_b_c2_en", 16'(en_b), 16'b00100);
        @(negedge clk); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("br_b_c3_en", 16'(en_b), 16'b11111);
        chk("br_b_c3_ctrl", 16'(ib.ctrl_out), 16'h0);
        chk("br_a_en", 16'(en_a), 16'b11111);
        @(negedge clk); idle(); #1;
        chk("br_b_flush_en", 16'(en_b), 16'b11110);
        chk("br_b_flush_ctrl", 16'(ib.ctrl_out), 16'(CTRL));
        chk("br_a_run_en", 16'(en_a), 16'b11100);
        chk("br_a_cnt", ia.bubble_cnt, 16'd4);
        @(negedge clk); #1;
        chk("br_b_run_en", 16'(en_b), 16'b11100);
        chk("br_b_cnt", ib.bubble_cnt, 16'd3);

        // Freeze during LU_HOLD on B
        @(negedge clk); lu5(); #1;
        chk("busy_b_lu_en", 16'(en_b), 16'b00100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
            chk("busy_b_en", 16'(en_b), 16'h0);
            chk("busy_b_ctrl", 16'(ib.ctrl_out), 16'(CTRL));
            chk("busy_b_cnt", ib.bubble_cnt, 16'd4);
            chk("busy_a_en", 16'(en_a), 16'h0);
            chk("busy_a_cnt", ia.bubble_cnt, 16'd5);
        end
        @(negedge clk); idle(); #1;
        chk("busy_b_resume1", 16'(en_b), 16'b00100);
        chk("busy_b_resume1_cnt", ib.bubble_cnt, 16'd4);
        @(negedge clk); #1;
        chk("busy_b_resume2", 16'(en_b), 16'b00100);
        chk("busy_b_resume2_cnt", ib.bubble_cnt, 16'd5);
        @(negedge clk); #1;
        chk("busy_b_run", 16'(en_b), 16'b11100);
        chk("busy_b_run_cnt", ib.bubble_cnt, 16'd6);

        // mem_busy outranks branch and load-use
        @(negedge clk); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        chk("prio_busy_a_en", 16'(en_a), 16'h0);
        chk("prio_busy_a_ctrl", 16'(ia.ctrl_out), 16'(CTRL));

        // Jump flush, and load-use outranking jump
        @(negedge clk); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("jump_a_en", 16'(en_a), 16'b11110);
        chk("jump_a_ctrl", 16'(ia.ctrl_out), 16'(CTRL));
        chk("jump_b_en", 16'(en_b), 16'b11110);
        @(negedge clk); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("jump_lu_a_en", 16'(en_a), 16'b00100);

        // Reset asserted in FLUSH on B
        @(negedge clk); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("rstfl_b_br_en", 16'(en_b), 16'b11111);
        @(negedge clk); idle(); reset_b = 1'b1; #1;
        chk("rstfl_b_en", 16'(en_b), 16'h0);
        chk("rstfl_b_ctrl", 16'(ib.ctrl_out), 16'h0);
        chk("rstfl_b_cnt", ib.bubble_cnt, 16'h0);
        @(negedge clk); reset_b = 1'b0; #1;
        chk("rstfl_b_run_en", 16'(en_b), 16'b11100);
        chk("rstfl_b_run_ctrl", 16'(ib.ctrl_out), 16'(CTRL));

        // Saturation of the bubble counter on A under a continuous load-use hazard
        @(negedge clk); reset_a = 1'b1; #1;
        chk("sat_a_rst_cnt", ia.bubble_cnt, 16'h0);
        @(negedge clk); reset_a = 1'b0; lu5();
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_a_fffe", ia.bubble_cnt, 16'hFFFE);
        @(negedge clk); #1;
        chk("sat_a_ffff", ia.bubble_cnt, 16'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        chk("sat_a_hold", ia.bubble_cnt, 16'hFFFF);
        chk("sat_a_en", 16'(en_a), 16'b00100);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
